game_status: RTL and testbench

GAME_STATUS -- requirements
Module: game_status

---
 rtl/game_pkg.sv | 17 +
 rtl/rise_detect.sv | 33 +++
 rtl/game_status.sv | 145 ++++++++++++++
 tb/tb_game_status.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game status block: FSM state codes and the
// default game constants used as parameter defaults by game_status.
package game_pkg;

   // State codes are visible on the state output, so the encoding is fixed.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      HIT  = 2'd2,
      OVER = 2'd3
   } state_e;

   localparam int LIVES_INIT_DEF   = 3;
   localparam int GRACE_FRAMES_DEF = 60;
   localparam int GRACE_W          = 8;   // holds GRACE_FRAMES up to 255

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level collision input: one sync register,
// one prev register, and a registered one-cycle pulse on a 0->1 change.
// The pulse appears two clocks after the input rises, so the consumer acts
// on it at the third clock edge.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic level_i,
   output logic rise_o
);

   logic sync_q;
   logic prev_q;
   logic rise_q;

   // Sample the level, keep the previous sample and register the 0->1 pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         // NOTE: non-blocking, so each stage takes its source's pre-edge value
         // and the chain really is three flops rather than one.
         sync_q <= level_i;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/game_status.sv
// Game status controller: start / play / hit / game-over FSM with lives,
// saturating star score and an optional post-hit grace window.
// Build option: define GRACE_TIMER_EN to enable the HIT state and grace
// counter; without it a tube hit costs a life but play continues at once.
module game_status
   import game_pkg::*;
#(
   parameter int LIVES_INIT   = LIVES_INIT_DEF,
   parameter int GRACE_FRAMES = GRACE_FRAMES_DEF,
   parameter int SCORE_W      = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_btn,
   input  logic               frame_tick,
   input  logic               collision_tube,
   input  logic               collision_star,
   output logic [1:0]         state,
   output logic [1:0]         lives,
   output logic [SCORE_W-1:0] score,
   output logic               hit_flash,
   output logic               game_over
);

   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
   localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);

   state_e             state_q, state_d;
   logic [1:0]         lives_q, lives_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               game_over_q;
   logic               tube_rise;
   logic               star_rise;

`ifdef GRACE_TIMER_EN
   localparam logic [GRACE_W-1:0] GRACE_LOAD = GRACE_W'(GRACE_FRAMES);
   logic [GRACE_W-1:0] grace_q, grace_d;
   logic               hit_flash_q;
`else
   // Grace timing has no function in this build.
   logic unused_cfg;
   assign unused_cfg = frame_tick | (GRACE_FRAMES == 0);
`endif

   rise_detect u_tube_rise (
      .clk     (clk),
      .rst     (rst),
      .level_i (collision_tube),
      .rise_o  (tube_rise)
   );

   rise_detect u_star_rise (
      .clk     (clk),
      .rst     (rst),
      .level_i (collision_star),
      .rise_o  (star_rise)
   );

   // Next-state logic: game progression, lives, score and grace countdown.
   always_comb begin
      // NOTE: every target gets a hold value first so no path leaves it
      // unassigned, which would infer a latch.
      state_d = state_q;
      lives_d = lives_q;
      score_d = score_q;
`ifdef GRACE_TIMER_EN
      grace_d = grace_q;
`endif

      // Stars count in both live states, even on the hit that ends the game.
      if ((state_q == PLAY || state_q == HIT) && star_rise && score_q != SCORE_MAX) begin
         score_d = score_q + SCORE_W'(1);
      end

      unique case (state_q)
         IDLE, OVER: begin
            if (start_btn) begin
               state_d = PLAY;
               lives_d = LIVES_LOAD;
               score_d = '0;
`ifdef GRACE_TIMER_EN
               grace_d = '0;
`endif
            end
         end
         PLAY: begin
            if (tube_rise) begin
               if (lives_q > 2'd1) begin
                  lives_d = lives_q - 2'd1;
`ifdef GRACE_TIMER_EN
                  grace_d = GRACE_LOAD;
                  state_d = HIT;
`endif
               end else begin
                  lives_d = 2'd0;
                  state_d = OVER;
               end
            end
         end
         HIT: begin
`ifdef GRACE_TIMER_EN
            // Tube contact is harmless here; only frame ticks matter.
            if (frame_tick) begin
               grace_d = grace_q - GRACE_W'(1);
               if (grace_q == GRACE_W'(1)) state_d = PLAY;
            end
`endif
         end
      endcase
   end

   // State registers; status flags decode the next state so they are flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lives_q     <= 2'd0;
         score_q     <= '0;
         game_over_q <= 1'b0;
`ifdef GRACE_TIMER_EN
         grace_q     <= '0;
         hit_flash_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         score_q     <= score_d;
         game_over_q <= (state_d == OVER);
`ifdef GRACE_TIMER_EN
         grace_q     <= grace_d;
         hit_flash_q <= (state_d == HIT);
`endif
      end
   end

   assign state     = state_q;
   assign lives     = lives_q;
   assign score     = score_q;
   assign game_over = game_over_q;
`ifdef GRACE_TIMER_EN
   assign hit_flash = hit_flash_q;
`else
   assign hit_flash = 1'b0;
`endif

endmodule

// File: tb/tb_game_status.sv
// Self-checking bench for game_status: two instances (full-size, and a
// 2-bit score / 2-life variant) share one stimulus stream and are compared
// every cycle against a behavioural model, plus literal directed checks.
module tb_game_status;

`ifdef GRACE_TIMER_EN
   localparam bit GRACE_EN = 1'b1;
`else
   localparam bit GRACE_EN = 1'b0;
`endif
   localparam int HIT_ST = GRACE_EN ? 2 : 1;   // state right after a non-fatal hit

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_btn = 1'b0;
   logic frame_tick = 1'b0;
   logic collision_tube = 1'b0;
   logic collision_star = 1'b0;

   logic [1:0] st0, lv0, st1, lv1;
   logic [9:0] sc0;
   logic [1:0] sc1;
   logic       hf0, go0, hf1, go1;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   always #5 clk = ~clk;

   game_status #(.LIVES_INIT(3), .GRACE_FRAMES(4), .SCORE_W(10)) u_dut0 (
      .clk(clk), .rst(rst), .start_btn(start_btn), .frame_tick(frame_tick),
      .collision_tube(collision_tube), .collision_star(collision_star),
      .state(st0), .lives(lv0), .score(sc0), .hit_flash(hf0), .game_over(go0)
   );

   game_status #(.LIVES_INIT(2), .GRACE_FRAMES(2), .SCORE_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .start_btn(start_btn), .frame_tick(frame_tick),
      .collision_tube(collision_tube), .collision_star(collision_star),
      .state(st1), .lives(lv1), .score(sc1), .hit_flash(hf1), .game_over(go1)
   );

   // ---------------- behavioural model ----------------
   int li   [2] = '{3, 2};
   int gf   [2] = '{4, 2};
   int smax [2] = '{1023, 3};
   int m_state [2] = '{0, 0};   // 0 idle, 1 play, 2 hit, 3 over
   int m_lives [2] = '{0, 0};
   int m_score [2] = '{0, 0};
   int m_grace [2] = '{0, 0};
   logic [2:0] th = 3'b000;     // th[0] = input before previous edge, etc.
   logic [2:0] sh = 3'b000;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_state[i] = 0; m_lives[i] = 0; m_score[i] = 0; m_grace[i] = 0;
      end
      th = 3'b000;
      sh = 3'b000;
   endtask

   // A level rising before edge k is acted on at edge k+2.
   task automatic model_step(input int i, input logic et, input logic es);
      case (m_state[i])
         0, 3: if (start_btn) begin
            m_state[i] = 1; m_lives[i] = li[i]; m_score[i] = 0; m_grace[i] = 0;
         end
         1: begin
            if (es && m_score[i] < smax[i]) m_score[i] = m_score[i] + 1;
            if (et) begin
               if (m_lives[i] > 1) begin
                  m_lives[i] = m_lives[i] - 1;
                  if (GRACE_EN) begin
                     m_grace[i] = gf[i];
                     m_state[i] = 2;
                  end
               end else begin
                  m_lives[i] = 0;
                  m_state[i] = 3;
               end
            end
         end
         2: begin
            if (es && m_score[i] < smax[i]) m_score[i] = m_score[i] + 1;
            if (frame_tick) begin
               m_grace[i] = m_grace[i] - 1;
               if (m_grace[i] == 0) m_state[i] = 1;
            end
         end
         default: ;
      endcase
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset();
      end else begin
         logic et;
         logic es;
         et = th[1] & ~th[2];
         es = sh[1] & ~sh[2];
         for (int i = 0; i < 2; i++) model_step(i, et, es);
         th = {th[1:0], collision_tube};
         sh = {sh[1:0], collision_star};
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("u0.state", 32'(st0), 32'(m_state[0]));
         check("u0.lives", 32'(lv0), 32'(m_lives[0]));
         check("u0.score", 32'(sc0), 32'(m_score[0]));
         check("u0.hit_flash", 32'(hf0), 32'(m_state[0] == 2));
         check("u0.game_over", 32'(go0), 32'(m_state[0] == 3));
         check("u1.state", 32'(st1), 32'(m_state[1]));
         check("u1.lives", 32'(lv1), 32'(m_lives[1]));
         check("u1.score", 32'(sc1), 32'(m_score[1]));
         check("u1.hit_flash", 32'(hf1), 32'(m_state[1] == 2));
         check("u1.game_over", 32'(go1), 32'(m_state[1] == 3));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tube_pulse();
      collision_tube = 1'b1; tick(1);
      collision_tube = 1'b0; tick(3);
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         frame_tick = 1'b1; tick(1);
         frame_tick = 1'b0; tick(1);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tick(3);
      rst = 1'b0;
      cmp_en = 1'b1;
      check("reset state", 32'(st0), 0);
      check("reset lives", 32'(lv0), 0);
      check("reset score", 32'(sc0), 0);
      check("reset game_over", 32'(go0), 0);
      check("reset hit_flash", 32'(hf0), 0);

      start_btn = 1'b1; tick(1); start_btn = 1'b0;
      check("start state", 32'(st0), 1);
      check("start lives", 32'(lv0), 3);
      check("start score", 32'(sc0), 0);
      check("start game_over", 32'(go0), 0);

      for (int k = 0; k < 3; k++) begin
         collision_star = 1'b1; tick(2);
         collision_star = 1'b0; tick(4);
      end
      check("three stars", 32'(sc0), 3);

      collision_star = 1'b1; tick(100);
      collision_star = 1'b0; tick(4);
      check("held star once", 32'(sc0), 4);
      check("small score saturates", 32'(sc1), 3);

      tube_pulse();
      check("first hit lives", 32'(lv0), 2);
      check("first hit state", 32'(st0), 32'(HIT_ST));
      check("first hit flash", 32'(hf0), 32'(GRACE_EN));

      tube_pulse();
      check("second hit lives", 32'(lv0), GRACE_EN ? 2 : 1);
      frames(3);
      check("grace 3 ticks state", 32'(st0), 32'(HIT_ST));
      frames(1);
      check("grace done state", 32'(st0), 1);
      check("grace done flash", 32'(hf0), 0);

`ifdef GRACE_TIMER_EN
      tube_pulse();
      check("third hit lives", 32'(lv0), 1);
      check("third hit state", 32'(st0), 2);
      frames(4);
      check("third grace done", 32'(st0), 1);
`endif

      // Star and tube rise together on the last life.
      collision_tube = 1'b1; collision_star = 1'b1; tick(1);
      collision_tube = 1'b0; collision_star = 1'b0; tick(3);
      check("final hit lives", 32'(lv0), 0);
      check("final hit state", 32'(st0), 3);
      check("final hit game_over", 32'(go0), 1);
      check("final hit star counted", 32'(sc0), 5);

      collision_star = 1'b1; tick(2); collision_star = 1'b0;
      tube_pulse();
      check("over score frozen", 32'(sc0), 5);
      check("over lives frozen", 32'(lv0), 0);

      // A level held across the restart must not count.
      collision_star = 1'b1; tick(5);
      start_btn = 1'b1; tick(1); start_btn = 1'b0;
      check("restart state", 32'(st0), 1);
      check("restart lives", 32'(lv0), 3);
      check("restart score", 32'(sc0), 0);
      tick(10);
      check("held level no edge", 32'(sc0), 0);
      collision_star = 1'b0; tick(3);

      collision_star = 1'b1; tick(2); collision_star = 1'b0; tick(3);
      start_btn = 1'b1; tick(1); start_btn = 1'b0; tick(3);
      check("start ignored in play", 32'(sc0), 1);

      // Asynchronous reset in the middle of a grace window.
      tube_pulse();
      frames(1);
      @(posedge clk); #2;
      rst = 1'b1; #1;
      check("async rst state", 32'(st0), 0);
      check("async rst lives", 32'(lv0), 0);
      check("async rst score", 32'(sc0), 0);
      check("async rst hit_flash", 32'(hf0), 0);
      check("async rst game_over", 32'(go0), 0);
      tick(2);
      rst = 1'b0; tick(3);
      check("post rst idle", 32'(st0), 0);

      // Randomised play against the model.
      for (int c = 0; c < 3000; c++) begin
         start_btn  = ($urandom_range(0, 39) == 0);
         frame_tick = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 11) == 0) collision_tube = ~collision_tube;
         if ($urandom_range(0, 5) == 0)  collision_star = ~collision_star;
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 799) == 0) rst = 1'b1;
         tick(1);
      end
      rst = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
